// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin block arbiter in front of main memory
//
// Purpose:
//   Arbitrates block refill reads and write-backs from the instruction cache
//   (requester 0) and the data cache (requester 1) onto a single main-memory
//   port. One access is in flight at a time. Each access passes through
//   IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (one cycle) -> IDLE.
//
// Parameters:
//   MEM_LATENCY     main-memory cycles per access, 1..15
//
// Ports:
//   clk             single clock, rising edge
//   reset_n         asynchronous active-low reset
//   reqN_valid      requester N access request (N = 0, 1)
//   reqN_write      1 = block write-back, 0 = block refill read
//   reqN_addr       requester N byte address (10 bits)
//   reqN_wdata      requester N write-back block (128 bits)
//   reqN_ready      request accepted this cycle
//   respN_valid     one-cycle completion pulse to requester N
//   resp_rdata      last block read from memory, shared by both requesters
//   mem_en          memory access active
//   mem_isRead      1 = read, 0 = write
//   mem_address     32-bit block-aligned memory address
//   mem_write_data  block written to memory
//   mem_read_data   memory read block, valid in the last BUSY cycle

module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         req0_valid,
  input  logic         req0_write,
  input  logic [9:0]   req0_addr,
  input  logic [127:0] req0_wdata,
  output logic         req0_ready,
  output logic         resp0_valid,

  input  logic         req1_valid,
  input  logic         req1_write,
  input  logic [9:0]   req1_addr,
  input  logic [127:0] req1_wdata,
  output logic         req1_ready,
  output logic         resp1_valid,

  output logic [127:0] resp_rdata,

  output logic         mem_en,
  output logic         mem_isRead,
  output logic [31:0]  mem_address,
  output logic [127:0] mem_write_data,
  input  logic [127:0] mem_read_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] COUNT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0]   state;
  logic [3:0]   count;
  // 1 means requester 1 was granted most recently, so requester 0 wins a tie.
  logic         lastGrant;
  logic         curId;
  logic         curWrite;
  // Only the block index is kept; the byte offset never reaches memory.
  logic [5:0]   curBlock;
  logic [127:0] curWdata;
  logic [127:0] rdataQ;

  logic         grant0;
  logic         grant1;
  logic         handshake;
  logic         busy;

  // Grant is purely combinational and only exists in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = lastGrant;
        grant1 = !lastGrant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Gating with reset_n keeps ready low while reset is held, even though the
  // forced IDLE state would otherwise let a valid request see a grant.
  assign req0_ready = grant0 && reset_n;
  assign req1_ready = grant1 && reset_n;
  assign handshake  = (grant0 && req0_valid) || (grant1 && req1_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 4'd0;
      lastGrant <= 1'b1;
      curId     <= 1'b0;
      curWrite  <= 1'b0;
      curBlock  <= 6'd0;
      curWdata  <= 128'd0;
      rdataQ    <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            curId     <= grant1;
            curWrite  <= grant1 ? req1_write      : req0_write;
            curBlock  <= grant1 ? req1_addr[9:4]  : req0_addr[9:4];
            curWdata  <= grant1 ? req1_wdata      : req0_wdata;
            lastGrant <= grant1;
            count     <= COUNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (count == 4'd0) begin
            // Memory presents read data in the final BUSY cycle only.
            if (!curWrite) begin
              rdataQ <= mem_read_data;
            end
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs depend only on latched state, so a non-granted
  // requester can never disturb an access in flight.
  assign busy           = (state == BUSY);
  assign mem_en         = busy;
  assign mem_isRead     = busy ? !curWrite : 1'b1;
  assign mem_address    = busy ? {22'd0, curBlock, 4'b0000} : 32'd0;
  assign mem_write_data = busy ? curWdata : 128'd0;

  assign resp0_valid = (state == RESP) && !curId;
  assign resp1_valid = (state == RESP) && curId;
  assign resp_rdata  = rdataQ;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning main-memory cycles per access; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 (instruction cache) access request.
REQ-005 SHALL have port req0_write  input  1  1 = block write-back, 0 = block refill read.
REQ-006 SHALL have port req0_addr  input  10  requester 0 byte address.
REQ-007 SHALL have port req0_wdata  input  128  requester 0 write-back block.
REQ-008 SHALL have port req0_ready  output  1  request accepted this cycle.
REQ-009 SHALL have port resp0_valid  output  1  one-cycle completion pulse to requester 0.
REQ-010 SHALL have ports req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid, with the same directions, widths and meanings, for requester 1 (data cache).
REQ-011 SHALL have port resp_rdata  output  128  last block read from memory, shared by both requesters.
REQ-012 SHALL have port mem_en  output  1  memory access active.
REQ-013 SHALL have port mem_isRead  output  1  1 = read, 0 = write.
REQ-014 SHALL have port mem_address  output  32  memory address.
REQ-015 SHALL have port mem_write_data  output  128  block written to memory.
REQ-016 SHALL have port mem_read_data  input  128  memory read block; valid in the last BUSY cycle.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-018 In IDLE, grant SHALL be computed combinationally: only one valid -> that requester; both valid -> the requester not granted last (round robin); neither -> no grant.
REQ-019 reqN_ready SHALL be high only in IDLE while requester N is granted; a handshake is reqN_valid & reqN_ready in the same cycle.
REQ-020 On a handshake, the arbiter SHALL latch requester id, write flag, address and wdata; update last_grant; load the counter with MEM_LATENCY-1; and go to BUSY.
REQ-021 In BUSY, mem_en SHALL be 1.
REQ-022 In BUSY, mem_isRead SHALL equal the inverse of the latched write flag.
REQ-023 In BUSY, mem_address SHALL be {22'b0, addr[9:4], 4'b0000}.
REQ-024 In BUSY, mem_write_data SHALL be the latched wdata.
REQ-025 Outside BUSY, mem_en SHALL be 0, mem_isRead 1, and mem_address and mem_write_data 0.
REQ-026 The counter SHALL decrement each BUSY cycle; BUSY SHALL last exactly MEM_LATENCY cycles.
REQ-027 In the final BUSY cycle (counter==0), a read SHALL capture mem_read_data into resp_rdata, and the FSM SHALL go to RESP.
REQ-028 A write SHALL leave resp_rdata unchanged.
REQ-029 RESP SHALL last one cycle, with resp0_valid or resp1_valid high according to the latched id, then return to IDLE.
REQ-030 Latency: handshake in cycle T; resp pulse in cycle T+MEM_LATENCY+1; next handshake no earlier than T+MEM_LATENCY+2.
REQ-031 Requests arriving in BUSY or RESP SHALL be held off (ready=0) and never dropped; a requester SHALL hold valid and payload until ready.
REQ-032 Deasserting valid before ready SHALL be legal and SHALL leave no side effect.
REQ-033 Inputs of a non-granted requester SHALL never affect memory-side outputs.
REQ-034 At most one resp pulse SHALL occur per handshake, and never both resp0_valid and resp1_valid at once.

Reset
REQ-035 reset_n low SHALL immediately force state IDLE, counter 0 and resp_rdata 0.
REQ-036 reset_n low SHALL immediately force reqN_ready, respN_valid and mem_en to 0, mem_isRead to 1, and mem_address and mem_write_data to 0.
REQ-037 reset_n low SHALL set last_grant to 1, so requester 0 wins the first tie.
REQ-038 Reset mid-BUSY or mid-RESP SHALL abort the access with no resp pulse; operation SHALL resume in the first cycle after reset_n rises.

Verification
REQ-039 The bench SHALL cover: MEM_LATENCY=4, req0 read addr 0x3A8, mem_read_data=0x0123..EF -> mem_en high 4 cycles with mem_address 0x000003A0; resp0_valid at T+5; resp_rdata=0x0123..EF.
REQ-040 The bench SHALL cover: req1 write addr 0x010, wdata=all-ones -> mem_isRead=0, mem_write_data=all-ones for 4 cycles; resp1_valid at T+5; resp_rdata unchanged.
REQ-041 The bench SHALL cover: both valid out of reset, held -> order req0, req1, req0, req1 with handshakes 6 cycles apart.
REQ-042 The bench SHALL cover: req0 valid during req1's BUSY -> req0_ready=0 until IDLE, then serviced; no request lost.
REQ-043 The bench SHALL cover: reset_n pulsed low in the 2nd BUSY cycle -> mem_en=0 immediately; no resp pulse; a new request afterward completes normally.
REQ-044 The bench SHALL cover: MEM_LATENCY=1 -> resp pulse at T+2; back-to-back handshakes 3 cycles apart.
